// File: rtl/kat_adc3wire_rx.sv
// KAT ADC 3-wire configuration receiver: oversampled serial decode into a 16x16 register file.
// Optional saturating rejected-frame counter enabled by KAT_ADC3WIRE_ERRCNT_EN.
module kat_adc3wire_rx #(
  parameter int          SYNC_STAGES = 2,
  parameter int          FRAME_BITS  = 32,
  parameter logic [11:0] HEADER      = 12'h001
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        adc3wire_clk_i,
  input  logic        adc3wire_data_i,
  input  logic        adc3wire_strobe_i,
  output logic        cfg_wr_o,
  output logic [3:0]  cfg_addr_o,
  output logic [15:0] cfg_data_o,
  output logic        frame_err_o,
  output logic        busy_o,
  input  logic [3:0]  rd_addr_i,
  output logic [15:0] rd_data_o,
  output logic [7:0]  err_count_o
);

  typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_SHIFT, S_CHECK} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync, r_stb_sync, r_flush;
  logic                   r_clk_prev;
  logic                   w_sclk, w_sdat, w_strobe, w_sclk_rise, w_flushed;
  state_t                 r_state, w_state_nxt;
  logic                   w_clr, w_shift_en, w_frame_ok, w_commit, w_reject;
  logic [31:0]            r_shift;
  logic [5:0]             r_bit_cnt;
  logic [15:0]            r_regs [16];
  logic [3:0]             r_cfg_addr;
  logic [15:0]            r_cfg_data, r_rd_data;
  logic                   r_busy;

  assign w_sclk      = r_clk_sync[SYNC_STAGES-1];
  assign w_sdat      = r_dat_sync[SYNC_STAGES-1];
  assign w_strobe    = r_stb_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_clk_prev;
  // Synchronizer outputs hold reset values until the chain has refilled from the pins.
  assign w_flushed   = r_flush[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_clk_sync <= '0;
      r_dat_sync <= '0;
      r_stb_sync <= '1;
      r_flush    <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], adc3wire_clk_i};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], adc3wire_data_i};
      r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], adc3wire_strobe_i};
      r_flush    <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_clk_prev <= w_sclk;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= S_WAIT_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      S_WAIT_IDLE: if (w_flushed && w_strobe) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (!w_strobe) begin
          w_clr       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      // Strobe rise has priority over a coincident clock edge.
      S_SHIFT: begin
        if (w_strobe)         w_state_nxt = S_CHECK;
        else if (w_sclk_rise) w_shift_en  = 1'b1;
      end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  assign w_frame_ok = (r_bit_cnt == 6'(FRAME_BITS)) && (r_shift[31:20] == HEADER);
  assign w_commit   = (r_state == S_CHECK) && w_frame_ok;
  assign w_reject   = (r_state == S_CHECK) && !w_frame_ok;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_clr) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift <= {r_shift[30:0], w_sdat};
      // Saturate so an oversized frame can never alias to a legal count.
      if (r_bit_cnt != 6'h3F) r_bit_cnt <= r_bit_cnt + 6'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_data <= r_regs[rd_addr_i];
      if (w_commit) begin
        r_regs[r_shift[19:16]] <= r_shift[15:0];
        r_cfg_addr             <= r_shift[19:16];
        r_cfg_data             <= r_shift[15:0];
      end
    end
  end

`ifdef KAT_ADC3WIRE_ERRCNT_EN
  logic [7:0] r_err_cnt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)                     r_err_cnt <= '0;
    else if (w_reject && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
  end
  assign err_count_o = r_err_cnt;
`else
  assign err_count_o = 8'h00;
`endif

  assign cfg_wr_o    = w_commit;
  assign frame_err_o = w_reject;
  assign cfg_addr_o  = r_cfg_addr;
  assign cfg_data_o  = r_cfg_data;
  assign busy_o      = r_busy;
  assign rd_data_o   = r_rd_data;

endmodule

// File: doc/kat_adc3wire_rx.md
Name: kat_adc3wire_rx

Overview:
- Receiving end of the KAT ADC 3-wire serial configuration interface (clk, data, strobe). Used as the ADC-side register model.
- Oversamples the 3-wire lines in the wishbone clock domain and decodes 32-bit frames of the form {12-bit header, 4-bit addr, 16-bit data}, MSB first.
- Commits each valid frame into a 16x16 register file and reports frame errors.
- Used in FPGA loopback/emulation builds and as a synthesizable check of the controller's serial output.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on each 3-wire input (min 2).
- FRAME_BITS, 32, required bit count per frame.
- HEADER, 12'h001, required value of frame bits [31:20].

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- adc3wire_clk_i  in  1  serial clock; data sampled on its rising edge.
- adc3wire_data_i  in  1  serial data, MSB first.
- adc3wire_strobe_i  in  1  frame strobe, active low (low = frame in progress).
- cfg_wr_o  out  1  one-cycle pulse on valid frame commit.
- cfg_addr_o  out  4  address of last committed frame.
- cfg_data_o  out  16  data of last committed frame.
- frame_err_o  out  1  one-cycle pulse on rejected frame.
- busy_o  out  1  high while state != IDLE.
- rd_addr_i  in  4  register file read address.
- rd_data_o  out  16  register file read data, registered.
- err_count_o  out  8  saturating rejected-frame count (optional feature).

Behaviour:
- Reset (wb_rst_n_i low, async): all outputs 0; register file cleared to 0; synchronizers cleared to clk=0, data=0, strobe=1; state = WAIT_IDLE.
- Input path: each input passes through SYNC_STAGES flops. sclk_rise = sync clk 1 now AND 0 the previous cycle.
- Frame latency: sclk edge to shift register update is SYNC_STAGES+1 cycles.
- State WAIT_IDLE: stay until sync strobe = 1, then go to IDLE. This prevents decoding a frame that was already in progress when reset released.
- State IDLE: on sync strobe = 0, clear shift register and 6-bit bit counter, go to SHIFT.
- State SHIFT:
  - On each sclk_rise with strobe still 0: shift_reg <= {shift_reg[30:0], data}; counter increments, saturating at 63.
  - On sync strobe = 1: go to CHECK.
  - If strobe rises in the same cycle as sclk_rise, the strobe rise wins and the bit is discarded.
- State CHECK (one cycle):
  - Valid frame (counter == FRAME_BITS AND shift_reg[31:20] == HEADER): regfile[shift_reg[19:16]] <= shift_reg[15:0]; cfg_addr_o/cfg_data_o updated; cfg_wr_o pulses in this cycle.
  - Otherwise: frame_err_o pulses; register file and cfg outputs unchanged.
  - Next state: IDLE.
- Too many bits (>32) or too few bits: frame rejected. The counter saturates and never wraps, so 96 bits cannot look like 32.
- Back-to-back frames: if strobe falls again in the cycle after CHECK, the new frame is accepted. Minimum strobe-high time is 2 wb_clk cycles beyond synchronizer delay.
- Read port: rd_data_o <= regfile[rd_addr_i] every cycle (1-cycle latency).
- Read/write collision: same address written in the same cycle returns the old value, new value the following cycle.
- cfg_wr_o and frame_err_o are never high together.

Optional Feature:
- Macro KAT_ADC3WIRE_ERRCNT_EN.
- Defined: err_count_o increments on each frame_err_o pulse, saturates at 8'hFF, cleared only by reset.
- Undefined: counter logic absent; err_count_o tied to 8'h00.

Test Plan:
- Valid frame: drive word 32'h0015_A5C3 with 16-cycle sclk, strobe low for the full frame -> cfg_wr_o one pulse, cfg_addr_o=4'h5, cfg_data_o=16'hA5C3; rd_addr_i=5 gives rd_data_o=16'hA5C3 one cycle later; frame_err_o stays 0.
- Bad header: 32'h0025_1234 -> frame_err_o one pulse, no cfg_wr_o, regfile[5] still 16'hA5C3; err_count_o=1 if KAT_ADC3WIRE_ERRCNT_EN is defined, else 0.
- Short/long frames: 31 bits then 33 bits of 32'h001F_FFFF pattern -> two frame_err_o pulses; regfile[F] stays 16'h0000.
- Back-to-back: frames 32'h0010_0001 and 32'h0011_0002 separated by 4 cycles of strobe high -> two cfg_wr_o pulses; regfile[0]=1, regfile[1]=2.
- Reset mid-frame: assert wb_rst_n_i after 10 bits, release with strobe still low, finish the 22 remaining bits -> no cfg_wr_o, no frame_err_o, busy_o=1 until strobe high, all outputs 0. A following valid frame then commits normally.
- Strobe/clock race: final sclk rise in the same synchronized cycle as strobe rise -> bit discarded, 31 bits counted, frame_err_o pulses.
